// File: rtl/inst_mem.sv
// Memory-access stage: issues dmem loads/stores over a req/ack handshake, formats load data,
// folds misalignment and bus timeouts into the trap fields, and registers the mem2wb stage.
module inst_mem #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex2mem_valid_ffout,
    input  logic        ex2mem_ld_ffout,
    input  logic        ex2mem_st_ffout,
    input  logic [2:0]  ex2mem_funct3_ffout,
    input  logic [31:0] ex2mem_addr_ffout,
    input  logic [31:0] ex2mem_stdata_ffout,
    input  logic [31:0] ex2mem_pc_ffout,
    input  logic        ex2mem_wr_reg_ffout,
    input  logic [4:0]  ex2mem_wr_regindex_ffout,
    input  logic [31:0] ex2mem_wr_wdata_ffout,
    input  logic        ex2mem_rd_is_x1_ffout,
    input  logic        ex2mem_rd_is_xn_ffout,
    input  logic        ex2mem_rv16_ffout,
    input  logic        ex2mem_wr_csrreg_ffout,
    input  logic [11:0] ex2mem_wr_csrindex_ffout,
    input  logic [31:0] ex2mem_wr_csrwdata_ffout,
    input  logic        ex2mem_mstatus_pmie_ffout,
    input  logic        ex2mem_mstatus_mie_ffout,
    input  logic [31:0] ex2mem_mtvec_ffout,
    input  logic        ex2mem_exp_ffout,
    input  logic [4:0]  ex2mem_causecode_ffout,
    input  logic [31:0] ex2mem_mtval_ffout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem2wb_valid_ffout,
    output logic        mem2wb_ld_ffout,
    output logic        mem2wb_st_ffout,
    output logic [2:0]  mem2wb_funct3_ffout,
    output logic [31:0] mem2wb_addr_ffout,
    output logic [31:0] mem2wb_stdata_ffout,
    output logic [31:0] mem2wb_pc_ffout,
    output logic        mem2wb_wr_reg_ffout,
    output logic [4:0]  mem2wb_wr_regindex_ffout,
    output logic [31:0] mem2wb_wr_wdata_ffout,
    output logic        mem2wb_rd_is_x1_ffout,
    output logic        mem2wb_rd_is_xn_ffout,
    output logic        mem2wb_rv16_ffout,
    output logic        mem2wb_wr_csrreg_ffout,
    output logic [11:0] mem2wb_wr_csrindex_ffout,
    output logic [31:0] mem2wb_wr_csrwdata_ffout,
    output logic        mem2wb_mstatus_pmie_ffout,
    output logic        mem2wb_mstatus_mie_ffout,
    output logic [31:0] mem2wb_mtvec_ffout,
    output logic        mem2wb_exp_ffout,
    output logic [4:0]  mem2wb_causecode_ffout,
    output logic [31:0] mem2wb_mtval_ffout,
    output logic [31:0] mem2wb_mepc_ffout
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    typedef struct packed {
        logic        valid;
        logic        ld;
        logic        st;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] stdata;
        logic [31:0] pc;
        logic        wr_reg;
        logic [4:0]  wr_regindex;
        logic [31:0] wr_wdata;
        logic        rd_is_x1;
        logic        rd_is_xn;
        logic        rv16;
        logic        wr_csrreg;
        logic [11:0] wr_csrindex;
        logic [31:0] wr_csrwdata;
        logic        mstatus_pmie;
        logic        mstatus_mie;
        logic [31:0] mtvec;
        logic        exp;
        logic [4:0]  causecode;
        logic [31:0] mtval;
        logic [31:0] mepc;
    } wb_t;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    wb_t         mem2wb_q, mem2wb_d;

    wb_t         pass, fault;
    logic        is_mem, misaligned, timeout_hit;
    logic [31:0] lane, ld_data, st_wdata;
    logic [3:0]  st_be;

    assign is_mem      = ex2mem_ld_ffout | ex2mem_st_ffout;
    assign timeout_hit = (cnt_q == CntLast);

    // Byte ops never fault; halves need addr[0]=0; everything else is treated as a word.
    always_comb begin
        unique case (ex2mem_funct3_ffout[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex2mem_addr_ffout[0];
            default: misaligned = |ex2mem_addr_ffout[1:0];
        endcase
    end

    always_comb begin
        pass = '{
            valid:        ex2mem_valid_ffout,
            ld:           ex2mem_ld_ffout,
            st:           ex2mem_st_ffout,
            funct3:       ex2mem_funct3_ffout,
            addr:         ex2mem_addr_ffout,
            stdata:       ex2mem_stdata_ffout,
            pc:           ex2mem_pc_ffout,
            wr_reg:       ex2mem_wr_reg_ffout,
            wr_regindex:  ex2mem_wr_regindex_ffout,
            wr_wdata:     ex2mem_wr_wdata_ffout,
            rd_is_x1:     ex2mem_rd_is_x1_ffout,
            rd_is_xn:     ex2mem_rd_is_xn_ffout,
            rv16:         ex2mem_rv16_ffout,
            wr_csrreg:    ex2mem_wr_csrreg_ffout,
            wr_csrindex:  ex2mem_wr_csrindex_ffout,
            wr_csrwdata:  ex2mem_wr_csrwdata_ffout,
            mstatus_pmie: ex2mem_mstatus_pmie_ffout,
            mstatus_mie:  ex2mem_mstatus_mie_ffout,
            mtvec:        ex2mem_mtvec_ffout,
            exp:          ex2mem_exp_ffout,
            causecode:    ex2mem_causecode_ffout,
            mtval:        ex2mem_mtval_ffout,
            mepc:         ex2mem_pc_ffout
        };
        fault           = pass;
        fault.exp       = 1'b1;
        fault.mtval     = ex2mem_addr_ffout;
        fault.wr_reg    = 1'b0;
        fault.wr_csrreg = 1'b0;
    end

    assign lane = dmem_rdata >> {ex2mem_addr_ffout[1:0], 3'b000};

    always_comb begin
        case (ex2mem_funct3_ffout)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_data = {24'd0, lane[7:0]};
            3'b101:  ld_data = {16'd0, lane[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex2mem_stdata_ffout;
        case (ex2mem_funct3_ffout[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex2mem_addr_ffout[1:0];
                st_wdata = {4{ex2mem_stdata_ffout[7:0]}};
            end
            2'b01: begin
                st_be    = ex2mem_addr_ffout[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex2mem_stdata_ffout[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            mem2wb_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            mem2wb_q <= mem2wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ex2mem_valid_ffout && is_mem && !ex2mem_exp_ffout && !misaligned) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                if (dmem_ack || timeout_hit) state_d = StIdle;
                else                         cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        mem2wb_d  = '0;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        unique case (state_q)
            StIdle: begin
                if (!ex2mem_valid_ffout) begin
                    mem2wb_d = '0;
                end else if (ex2mem_exp_ffout || !is_mem) begin
                    mem2wb_d = pass;
                end else if (misaligned) begin
                    mem2wb_d           = fault;
                    mem2wb_d.causecode = ex2mem_ld_ffout ? 5'd4 : 5'd6;
                end else begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = ex2mem_st_ffout;
                    addr_d    = {ex2mem_addr_ffout[31:2], 2'b00};
                    wdata_d   = st_wdata;
                    be_d      = ex2mem_st_ffout ? st_be : 4'b1111;
                end
            end
            StReq: begin
                if (dmem_ack) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    be_d     = 4'b0000;
                    mem2wb_d = pass;
                    if (ex2mem_ld_ffout) mem2wb_d.wr_wdata = ld_data;
                    else                 mem2wb_d.wr_reg   = 1'b0;
                end else if (timeout_hit) begin
                    req_d              = 1'b0;
                    we_d               = 1'b0;
                    be_d               = 4'b0000;
                    mem2wb_d           = fault;
                    mem2wb_d.causecode = ex2mem_ld_ffout ? 5'd5 : 5'd7;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign mem2wb_valid_ffout        = mem2wb_q.valid;
    assign mem2wb_ld_ffout           = mem2wb_q.ld;
    assign mem2wb_st_ffout           = mem2wb_q.st;
    assign mem2wb_funct3_ffout       = mem2wb_q.funct3;
    assign mem2wb_addr_ffout         = mem2wb_q.addr;
    assign mem2wb_stdata_ffout       = mem2wb_q.stdata;
    assign mem2wb_pc_ffout           = mem2wb_q.pc;
    assign mem2wb_wr_reg_ffout       = mem2wb_q.wr_reg;
    assign mem2wb_wr_regindex_ffout  = mem2wb_q.wr_regindex;
    assign mem2wb_wr_wdata_ffout     = mem2wb_q.wr_wdata;
    assign mem2wb_rd_is_x1_ffout     = mem2wb_q.rd_is_x1;
    assign mem2wb_rd_is_xn_ffout     = mem2wb_q.rd_is_xn;
    assign mem2wb_rv16_ffout         = mem2wb_q.rv16;
    assign mem2wb_wr_csrreg_ffout    = mem2wb_q.wr_csrreg;
    assign mem2wb_wr_csrindex_ffout  = mem2wb_q.wr_csrindex;
    assign mem2wb_wr_csrwdata_ffout  = mem2wb_q.wr_csrwdata;
    assign mem2wb_mstatus_pmie_ffout = mem2wb_q.mstatus_pmie;
    assign mem2wb_mstatus_mie_ffout  = mem2wb_q.mstatus_mie;
    assign mem2wb_mtvec_ffout        = mem2wb_q.mtvec;
    assign mem2wb_exp_ffout          = mem2wb_q.exp;
    assign mem2wb_causecode_ffout    = mem2wb_q.causecode;
    assign mem2wb_mtval_ffout        = mem2wb_q.mtval;
    assign mem2wb_mepc_ffout         = mem2wb_q.mepc;

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: vector table driven through a stalling issuer, a bus
// responder with programmable ack delay, and a scoreboard on the mem2wb register.
module tb_inst_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex2mem_valid_ffout = 0, ex2mem_ld_ffout = 0, ex2mem_st_ffout = 0;
    logic [2:0]  ex2mem_funct3_ffout = '0;
    logic [31:0] ex2mem_addr_ffout = '0, ex2mem_stdata_ffout = '0, ex2mem_pc_ffout = '0;
    logic        ex2mem_wr_reg_ffout = 0;
    logic [4:0]  ex2mem_wr_regindex_ffout = '0;
    logic [31:0] ex2mem_wr_wdata_ffout = '0;
    logic        ex2mem_wr_csrreg_ffout = 0;
    logic        ex2mem_exp_ffout = 0;
    logic [4:0]  ex2mem_causecode_ffout = '0;
    logic [31:0] ex2mem_mtval_ffout = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [3:0]  dmem_be;
    logic        mem2wb_valid_ffout, mem2wb_ld_ffout, mem2wb_st_ffout, mem2wb_wr_reg_ffout;
    logic [2:0]  mem2wb_funct3_ffout;
    logic [31:0] mem2wb_addr_ffout, mem2wb_stdata_ffout, mem2wb_pc_ffout, mem2wb_wr_wdata_ffout;
    logic [4:0]  mem2wb_wr_regindex_ffout, mem2wb_causecode_ffout;
    logic        mem2wb_rd_is_x1_ffout, mem2wb_rd_is_xn_ffout, mem2wb_rv16_ffout;
    logic        mem2wb_wr_csrreg_ffout, mem2wb_mstatus_pmie_ffout, mem2wb_mstatus_mie_ffout;
    logic [11:0] mem2wb_wr_csrindex_ffout;
    logic [31:0] mem2wb_wr_csrwdata_ffout, mem2wb_mtvec_ffout, mem2wb_mtval_ffout;
    logic [31:0] mem2wb_mepc_ffout;
    logic        mem2wb_exp_ffout;

    inst_mem #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ex2mem_valid_ffout(ex2mem_valid_ffout), .ex2mem_ld_ffout(ex2mem_ld_ffout),
        .ex2mem_st_ffout(ex2mem_st_ffout), .ex2mem_funct3_ffout(ex2mem_funct3_ffout),
        .ex2mem_addr_ffout(ex2mem_addr_ffout), .ex2mem_stdata_ffout(ex2mem_stdata_ffout),
        .ex2mem_pc_ffout(ex2mem_pc_ffout), .ex2mem_wr_reg_ffout(ex2mem_wr_reg_ffout),
        .ex2mem_wr_regindex_ffout(ex2mem_wr_regindex_ffout),
        .ex2mem_wr_wdata_ffout(ex2mem_wr_wdata_ffout),
        .ex2mem_rd_is_x1_ffout(1'b0), .ex2mem_rd_is_xn_ffout(1'b0), .ex2mem_rv16_ffout(1'b0),
        .ex2mem_wr_csrreg_ffout(ex2mem_wr_csrreg_ffout), .ex2mem_wr_csrindex_ffout(12'h0),
        .ex2mem_wr_csrwdata_ffout(32'h0), .ex2mem_mstatus_pmie_ffout(1'b0),
        .ex2mem_mstatus_mie_ffout(1'b0), .ex2mem_mtvec_ffout(32'h0),
        .ex2mem_exp_ffout(ex2mem_exp_ffout), .ex2mem_causecode_ffout(ex2mem_causecode_ffout),
        .ex2mem_mtval_ffout(ex2mem_mtval_ffout),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .mem2wb_valid_ffout(mem2wb_valid_ffout), .mem2wb_ld_ffout(mem2wb_ld_ffout),
        .mem2wb_st_ffout(mem2wb_st_ffout), .mem2wb_funct3_ffout(mem2wb_funct3_ffout),
        .mem2wb_addr_ffout(mem2wb_addr_ffout), .mem2wb_stdata_ffout(mem2wb_stdata_ffout),
        .mem2wb_pc_ffout(mem2wb_pc_ffout), .mem2wb_wr_reg_ffout(mem2wb_wr_reg_ffout),
        .mem2wb_wr_regindex_ffout(mem2wb_wr_regindex_ffout),
        .mem2wb_wr_wdata_ffout(mem2wb_wr_wdata_ffout),
        .mem2wb_rd_is_x1_ffout(mem2wb_rd_is_x1_ffout),
        .mem2wb_rd_is_xn_ffout(mem2wb_rd_is_xn_ffout), .mem2wb_rv16_ffout(mem2wb_rv16_ffout),
        .mem2wb_wr_csrreg_ffout(mem2wb_wr_csrreg_ffout),
        .mem2wb_wr_csrindex_ffout(mem2wb_wr_csrindex_ffout),
        .mem2wb_wr_csrwdata_ffout(mem2wb_wr_csrwdata_ffout),
        .mem2wb_mstatus_pmie_ffout(mem2wb_mstatus_pmie_ffout),
        .mem2wb_mstatus_mie_ffout(mem2wb_mstatus_mie_ffout),
        .mem2wb_mtvec_ffout(mem2wb_mtvec_ffout), .mem2wb_exp_ffout(mem2wb_exp_ffout),
        .mem2wb_causecode_ffout(mem2wb_causecode_ffout),
        .mem2wb_mtval_ffout(mem2wb_mtval_ffout), .mem2wb_mepc_ffout(mem2wb_mepc_ffout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rdata;
        int          dly;          // ack delay in REQ cycles, -1 = never
        logic        exp_in;
        logic [4:0]  cause_in;
        logic [31:0] mtval_in;
        logic        wr_reg_in;
        logic        x_bus;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic        x_we;
        logic [31:0] x_wdata;
        int          x_req, x_stall;
        logic        x_wr_reg;
        logic [31:0] x_wb;
        logic        x_exp;
        logic [4:0]  x_cause;
        logic [31:0] x_mtval;
    } vec_t;

    typedef struct packed {
        logic        valid, wr_reg;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic        csr, exp;
        logic [4:0]  cause;
        logic [31:0] mtval, mepc;
    } wb_t;

    int   checks = 0, errors = 0;
    wb_t  sb_q[$];
    int   ack_dly = -1, wait_cnt = 0, req_cycles = 0;
    logic [31:0] rd_val = '0;
    logic stray_ack = 1'b0, bus_seen = 1'b0, cap_we = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_be = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Bus responder: updates at negedge so the DUT sees ack for the whole following edge.
    always @(negedge clk) begin
        if (dmem_req) begin
            req_cycles++;
            if (ack_dly >= 0 && wait_cnt == ack_dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd_val;
                bus_seen   = 1'b1;
                cap_addr   = dmem_addr;
                cap_be     = dmem_be;
                cap_we     = dmem_we;
                cap_wdata  = dmem_wdata;
            end else begin
                dmem_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            wait_cnt   = 0;
            dmem_ack   = stray_ack;
            dmem_rdata = stray_ack ? 32'hBAD0_BAD0 : rd_val;
        end
    end

    always @(negedge clk) begin
        wb_t got;
        if (!reset && mem2wb_valid_ffout) begin
            got = '{valid: mem2wb_valid_ffout, wr_reg: mem2wb_wr_reg_ffout,
                    idx: mem2wb_wr_regindex_ffout, wdata: mem2wb_wr_wdata_ffout,
                    csr: mem2wb_wr_csrreg_ffout, exp: mem2wb_exp_ffout,
                    cause: mem2wb_causecode_ffout, mtval: mem2wb_mtval_ffout,
                    mepc: mem2wb_mepc_ffout};
            if (sb_q.size() == 0) chk("wb_unexpected", 128'(got), 128'(0));
            else                  chk("wb_record", 128'(got), 128'(sb_q.pop_front()));
        end
    end

    task automatic drive(input vec_t v, input int idx);
        ex2mem_valid_ffout       = 1'b1;
        ex2mem_ld_ffout          = v.ld;
        ex2mem_st_ffout          = v.st;
        ex2mem_funct3_ffout      = v.f3;
        ex2mem_addr_ffout        = v.addr;
        ex2mem_stdata_ffout      = v.sd;
        ex2mem_pc_ffout          = 32'h100 + 32'(idx) * 4;
        ex2mem_wr_reg_ffout      = v.wr_reg_in;
        ex2mem_wr_regindex_ffout = 5'd5;
        ex2mem_wr_wdata_ffout    = 32'h1234;
        ex2mem_exp_ffout         = v.exp_in;
        ex2mem_causecode_ffout   = v.cause_in;
        ex2mem_mtval_ffout       = v.mtval_in;
    endtask

    task automatic issue(input vec_t v, input int idx);
        int stalls = 0;
        bit done = 0;
        @(posedge clk); #1;
        ack_dly = v.dly; rd_val = v.rdata; bus_seen = 1'b0; req_cycles = 0;
        drive(v, idx);
        sb_q.push_back('{valid: 1'b1, wr_reg: v.x_wr_reg, idx: 5'd5, wdata: v.x_wb, csr: 1'b0,
                         exp: v.x_exp, cause: v.x_cause, mtval: v.x_mtval,
                         mepc: 32'h100 + 32'(idx) * 4});
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk); #1;
            if (mem_stall) stalls++;
            else           done = 1;
        end
        if (!done) chk({v.name, "_stall_bound"}, 128'(done), 128'(1));
        chk({v.name, "_stall_cycles"}, 128'(stalls), 128'(v.x_stall));
        chk({v.name, "_req_cycles"}, 128'(req_cycles), 128'(v.x_req));
        chk({v.name, "_bus_acked"}, 128'(bus_seen), 128'(v.x_bus));
        if (bus_seen && v.x_bus) begin
            chk({v.name, "_dmem_addr"}, 128'(cap_addr), 128'(v.x_addr));
            chk({v.name, "_dmem_be"}, 128'(cap_be), 128'(v.x_be));
            chk({v.name, "_dmem_we"}, 128'(cap_we), 128'(v.x_we));
            if (v.x_we) chk({v.name, "_dmem_wdata"}, 128'(cap_wdata), 128'(v.x_wdata));
        end
    endtask

    vec_t vt[15];
    vec_t v_lbu, v_abort;

    initial begin
        bit found = 0;
        //        name  ld st f3 addr  sd  rdata  dly expin cause mtval wr | bus addr be we wdata
        //        req stall | wr_reg wb exp cause mtval
        vt[0]  = '{"alu", 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 1, 32'h1234, 0, 5'd0, 32'h0};
        vt[1]  = '{"lb", 1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_0000, 3, 0, 5'd0, 32'h0, 1,
                   1, 32'h1000, 4'hF, 0, 32'h0, 4, 4, 1, 32'hFFFF_FF80, 0, 5'd0, 32'h0};
        vt[2]  = '{"sh", 0, 1, 3'd1, 32'h2002, 32'hAABB_CCDD, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   1, 32'h2000, 4'hC, 1, 32'hCCDD_CCDD, 1, 1, 0, 32'h1234, 0, 5'd0, 32'h0};
        vt[3]  = '{"lw_mis", 1, 0, 3'd2, 32'h3001, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 0, 32'h1234, 1, 5'd4, 32'h3001};
        vt[4]  = '{"lh", 1, 0, 3'd1, 32'h4002, 32'h0, 32'h8001_1234, 1, 0, 5'd0, 32'h0, 1,
                   1, 32'h4000, 4'hF, 0, 32'h0, 2, 2, 1, 32'hFFFF_8001, 0, 5'd0, 32'h0};
        vt[5]  = '{"lhu", 1, 0, 3'd5, 32'h4002, 32'h0, 32'h8001_1234, 0, 0, 5'd0, 32'h0, 1,
                   1, 32'h4000, 4'hF, 0, 32'h0, 1, 1, 1, 32'h0000_8001, 0, 5'd0, 32'h0};
        vt[6]  = '{"sb", 0, 1, 3'd0, 32'h5001, 32'h1122_3344, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   1, 32'h5000, 4'h2, 1, 32'h4444_4444, 1, 1, 0, 32'h1234, 0, 5'd0, 32'h0};
        vt[7]  = '{"sw", 0, 1, 3'd2, 32'h6000, 32'hCAFE_BABE, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   1, 32'h6000, 4'hF, 1, 32'hCAFE_BABE, 1, 1, 0, 32'h1234, 0, 5'd0, 32'h0};
        vt[8]  = '{"lw", 1, 0, 3'd2, 32'h7000, 32'h0, 32'h1234_5678, 0, 0, 5'd0, 32'h0, 1,
                   1, 32'h7000, 4'hF, 0, 32'h0, 1, 1, 1, 32'h1234_5678, 0, 5'd0, 32'h0};
        vt[9]  = '{"sh_mis", 0, 1, 3'd1, 32'h2001, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 0, 32'h1234, 1, 5'd6, 32'h2001};
        vt[10] = '{"exp_in", 1, 0, 3'd0, 32'h1000, 32'h0, 32'h0, 0, 1, 5'd2, 32'hDEAD, 0,
                   0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 0, 32'h1234, 1, 5'd2, 32'hDEAD};
        vt[11] = '{"lw_tmo", 1, 0, 3'd2, 32'h8000, 32'h0, 32'h0, -1, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 4, 4, 0, 32'h1234, 1, 5'd5, 32'h8000};
        vt[12] = '{"sw_tmo", 0, 1, 3'd2, 32'h8004, 32'h0, 32'h0, -1, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 4, 4, 0, 32'h1234, 1, 5'd7, 32'h8004};
        vt[13] = '{"lw_ack4", 1, 0, 3'd2, 32'h8008, 32'h0, 32'hA5A5_A5A5, 3, 0, 5'd0, 32'h0, 1,
                   1, 32'h8008, 4'hF, 0, 32'h0, 4, 4, 1, 32'hA5A5_A5A5, 0, 5'd0, 32'h0};
        vt[14] = '{"alu2", 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 1, 32'h1234, 0, 5'd0, 32'h0};
        v_lbu   = '{"lbu", 1, 0, 3'd4, 32'h10, 32'h0, 32'h0000_00F0, 0, 0, 5'd0, 32'h0, 1,
                   1, 32'h10, 4'hF, 0, 32'h0, 1, 1, 1, 32'h0000_00F0, 0, 5'd0, 32'h0};
        v_abort = '{"abort", 1, 0, 3'd2, 32'h9000, 32'h0, 32'h0, -1, 0, 5'd0, 32'h0, 1,
                   0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 5'd0, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dmem_req", 128'(dmem_req), 128'(0));
        chk("rst_dmem_we", 128'(dmem_we), 128'(0));
        chk("rst_dmem_be", 128'(dmem_be), 128'(0));
        chk("rst_wb_bubble", 128'({mem2wb_valid_ffout, mem2wb_wr_reg_ffout,
            mem2wb_wr_csrreg_ffout, mem2wb_exp_ffout}), 128'(0));
        chk("rst_stall", 128'(mem_stall), 128'(0));
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 15; i++) issue(vt[i], i);
        @(posedge clk); #1 ex2mem_valid_ffout = 1'b0;

        // Stray ack while idle must not start or complete anything.
        stray_ack = 1'b1;
        @(negedge clk); #1;
        @(posedge clk); #1 stray_ack = 1'b0;
        chk("stray_ack_req", 128'(dmem_req), 128'(0));
        chk("stray_ack_wb", 128'(mem2wb_valid_ffout), 128'(0));

        // Reset in the middle of an outstanding request abandons it.
        @(posedge clk); #1;
        ack_dly = -1;
        drive(v_abort, 30);
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (dmem_req) found = 1;
        end
        chk("abort_req_seen", 128'(found), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("abort_req_drop", 128'(dmem_req), 128'(0));
        chk("abort_wb_wr_reg", 128'(mem2wb_wr_reg_ffout), 128'(0));
        ex2mem_valid_ffout = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        issue(v_lbu, 31);
        @(posedge clk); #1 ex2mem_valid_ffout = 1'b0;

        repeat (3) @(posedge clk);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
Name: inst_mem

Overview:
- Memory-access stage of the 5-stage RV32 pipeline, sitting between the ex2mem pipeline register and the writeback stage.
- Issues loads and stores to the data-memory port over a req/ack handshake, and formats load data (byte/half/word, signed/unsigned).
- Detects misaligned and timed-out accesses and folds them into the trap fields.
- Registers everything into the mem2wb_*_ffout pipeline register consumed by writeback.

Parameters:
TIMEOUT, 255, max cycles dmem_req is held without dmem_ack before raising an access fault (1..255).

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
ex2mem_valid_ffout  in  1  instruction present in MEM
ex2mem_ld_ffout / ex2mem_st_ffout  in  1/1  load / store
ex2mem_funct3_ffout  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
ex2mem_addr_ffout  in  32  effective address (ALU result)
ex2mem_stdata_ffout  in  32  store data (rs2)
ex2mem_pc_ffout  in  32  instruction PC
ex2mem_{wr_reg, wr_regindex[5], wr_wdata[32], rd_is_x1, rd_is_xn, rv16, wr_csrreg, wr_csrindex[12], wr_csrwdata[32], mstatus_pmie, mstatus_mie, mtvec[32], exp, causecode[5], mtval[32]}_ffout  in  various  upstream fields
dmem_req  out  1  bus request (registered)
dmem_we  out  1  write enable
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  bus completion; dmem_rdata valid this cycle
dmem_rdata  in  32  read data
mem_stall  out  1  hold ex2mem and upstream stages
mem2wb_{same field list as ex2mem, plus mepc[32]}_ffout  out  various  pipeline register to writeback

Behaviour:
- Reset (async):
  - state=IDLE, cnt=0, dmem_req=0, dmem_we=0, dmem_be=0.
  - All mem2wb_*_ffout=0, i.e. bubble: wr_reg=0, wr_csrreg=0, exp=0.
- Non-memory instruction (valid & !ld & !st), or valid & ex2mem_exp_ffout:
  - mem_stall=0; fields registered into mem2wb next edge, 1-cycle latency.
  - Incoming exp suppresses any bus access; exp/causecode/mtval pass through; mepc=pc.
- valid=0: mem2wb loads a bubble.
- Alignment check (ld|st, no incoming exp): H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned: no bus access, no stall.
  - mem2wb_exp=1, causecode=4 (load) / 6 (store), mtval=addr, mepc=pc, wr_reg=0, wr_csrreg=0.
- FSM IDLE/REQ:
  - IDLE, aligned ld|st: mem_stall=1. Next edge: state=REQ, dmem_req=1, dmem_we=st, addr/be/wdata latched, cnt=0, mem2wb loads bubble.
  - REQ, dmem_ack=1: mem_stall=0. Next edge: dmem_req=0, state=IDLE, mem2wb loads the instruction (load: wr_wdata=formatted rdata; store: wr_reg forced 0).
  - REQ, no ack: mem_stall=1, cnt++. If cnt==TIMEOUT-1, next edge: req dropped, state=IDLE, mem2wb_exp=1, causecode=5 (load) / 7 (store), mtval=addr, wr_reg=0; mem_stall=0 that cycle.
  - Ack on the timeout cycle: ack wins, no fault.
  - dmem_ack while IDLE is ignored.
  - dmem_req/we/addr/be/wdata stay stable while REQ.
- Minimum memory-op latency: 2 cycles (issue + ack). Back-to-back memory ops allowed; the 2nd is issued in the IDLE cycle following the ack.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{sd[15:0]}}.
  - SW: be=1111, wdata=sd.
- Load format: lane=rdata>>(8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
  - Unused funct3 values are treated as LW.
- Reset asserted mid-REQ: dmem_req drops immediately (async); the transaction is abandoned.

Test Plan:
- ALU op, wr_reg=1, regindex=5, wdata=0x1234 -> next cycle mem2wb_wr_reg=1, regindex=5, wdata=0x1234, mem_stall never high.
- LB addr=0x1003, ack 3 cycles after req with rdata=0x80FF_0000 -> dmem_addr=0x1000, be=1111, we=0; mem2wb_wr_wdata=0xFFFF_FF80; stall high 4 cycles.
- SH addr=0x2002 stdata=0xAABB_CCDD, immediate ack -> be=1100, wdata=0xCCDD_CCDD, we=1; mem2wb_wr_reg=0, exp=0.
- LW addr=0x3001 -> no dmem_req; mem2wb_exp=1, causecode=4, mtval=0x3001, mepc=pc, wr_reg=0.
- LW with ack withheld, TIMEOUT=4 -> req high exactly 4 cycles then drops; mem2wb_exp=1, causecode=5; separately, ack on the 4th cycle -> normal completion, no fault.
- Reset asserted while REQ -> dmem_req=0 and mem2wb_wr_reg=0 immediately; after release, an LBU to 0x10 with rdata=0x0000_00F0 -> wdata=0xF0.
